// File: rtl/sobel_line_buffer_if.sv
// sobel_line_buffer_if: pixel-in / triplet-out bundle between the line buffer and its neighbours
interface sobel_line_buffer_if #(
  parameter int PIXEL_WIDTH = 8
);
  logic                   start_frame_i;
  logic                   px_valid_i;
  logic [PIXEL_WIDTH-1:0] px_i;
  logic                   in_ready_o;
  logic [PIXEL_WIDTH-1:0] px_o;
  logic                   px_rdy_o;
  logic                   start_sobel_o;
  logic                   frame_done_o;

  modport master (
    output start_frame_i, px_valid_i, px_i,
    input  in_ready_o, px_o, px_rdy_o, start_sobel_o, frame_done_o
  );

  modport slave (
    input  start_frame_i, px_valid_i, px_i,
    output in_ready_o, px_o, px_rdy_o, start_sobel_o, frame_done_o
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: two-line buffer emitting serial vertical triplets to the Sobel stage; SOBEL_LB_PAD_EN zero-pads the top border
module sobel_line_buffer #(
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8,
  parameter int COL_BITS    = $clog2(IMG_WIDTH),
  parameter int ROW_BITS    = $clog2(IMG_HEIGHT)
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  sobel_line_buffer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FILL, WAIT_PX, EMIT, ROW_GAP, DONE} state_t;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(IMG_WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(IMG_HEIGHT - 1);
`ifdef SOBEL_LB_PAD_EN
  localparam state_t FIRST_ST = WAIT_PX;
`else
  localparam state_t FIRST_ST = FILL;
`endif

  state_t                 state_q, state_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [COL_BITS-1:0]    col_q, col_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   gap_q, gap_d;
  logic                   start_q, start_d;
  logic                   in_ready_q, in_ready_d;
  logic [PIXEL_WIDTH-1:0] top_q, mid_q, bot_q;
  logic [PIXEL_WIDTH-1:0] top_n, mid_n;
  logic [PIXEL_WIDTH-1:0] line0_q [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] line1_q [IMG_WIDTH];
  logic                   accept;

  assign accept = in_ready_q && bus.px_valid_i;

`ifdef SOBEL_LB_PAD_EN
  assign top_n = (row_q < ROW_BITS'(2)) ? '0 : line0_q[col_q];
  assign mid_n = (row_q == '0) ? '0 : line1_q[col_q];
`else
  assign top_n = line0_q[col_q];
  assign mid_n = line1_q[col_q];
`endif

  // Frame sequencing: fill, per-column accept/emit, row gap and frame end
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (bus.start_frame_i) begin
          state_d = FIRST_ST;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FILL: if (accept) begin
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        row_d = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;
        if (col_q == COL_LAST && row_q == ROW_BITS'(1)) state_d = WAIT_PX;
      end
      WAIT_PX: if (accept) begin
        state_d = EMIT;
        cnt_d   = '0;
        if (col_q == '0) start_d = 1'b1;
      end
      EMIT: begin
        if (cnt_q != 2'd2) cnt_d = cnt_q + 1'b1;
        else if (col_q != COL_LAST) begin
          col_d   = col_q + 1'b1;
          state_d = WAIT_PX;
        end else if (row_q != ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + 1'b1;
          gap_d   = 1'b0;
          start_d = 1'b0;
          state_d = ROW_GAP;
        end else begin
          start_d = 1'b0;
          state_d = DONE;
        end
      end
      ROW_GAP: begin
        gap_d = 1'b1;
        if (gap_q) state_d = WAIT_PX;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == FILL) || (state_d == WAIT_PX);
  end

  // Control state and counters, cleared asynchronously so an abort leaves no partial triplet
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      start_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      start_q    <= start_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Latch the column triplet only when it is about to be emitted so px_o holds between triplets
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (accept && state_q == WAIT_PX) begin
      top_q <= top_n;
      mid_q <= mid_n;
      bot_q <= bus.px_i;
    end
  end

  // Shift the column history down one line on every accepted pixel; contents need no reset
  always_ff @(posedge clk_i) begin
    if (accept) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= bus.px_i;
    end
  end

  assign bus.in_ready_o    = in_ready_q;
  assign bus.px_rdy_o      = (state_q == EMIT);
  assign bus.px_o          = (cnt_q == 2'd0) ? top_q : (cnt_q == 2'd1) ? mid_q : bot_q;
  assign bus.start_sobel_o = start_q;
  assign bus.frame_done_o  = (state_q == DONE);
endmodule

// File: tb/tb_sobel_line_buffer.sv
// tb_sobel_line_buffer: randomized scoreboard bench for sobel_line_buffer
module tb_sobel_line_buffer;
  localparam int W = 8;
  localparam int H = 8;
`ifdef SOBEL_LB_PAD_EN
  localparam int ROW0 = 0;
`else
  localparam int ROW0 = 2;
`endif
  localparam int NTRIP = (H - ROW0) * W;

  typedef struct packed {
    logic [7:0] v;
    bit         gap;
  } exp_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  sobel_line_buffer_if #(.PIXEL_WIDTH(8)) bus ();

  sobel_line_buffer #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk),
    .nreset_i(nreset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int   pass_cnt = 0;
  int   total    = 0;
  int   done_cnt = 0;
  int   el_cnt   = 0;
  int   gap_n    = 0;
  exp_t sb[$];
  logic [7:0] img [W*H];

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", n, a, e);
  endtask

  function automatic logic [7:0] pix(input int r, input int c);
    return (r < 0) ? 8'd0 : img[r*W+c];
  endfunction

  task automatic build_frame(input bit rnd);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W+c] = rnd ? 8'($urandom) : 8'(r*W+c);
    for (int r = ROW0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        sb.push_back('{v: pix(r-2, c), gap: 1'b0});
        sb.push_back('{v: pix(r-1, c), gap: 1'b0});
        sb.push_back('{v: pix(r, c), gap: (c == W-1) && (r != H-1)});
      end
  endtask

  // Monitor: compare every presented triplet pixel and the row-gap shape against the scoreboard
  always @(negedge clk) begin
    if (gap_n != 0) begin
      if (gap_n < 3) chk("row_gap_start_ready", {bus.start_sobel_o, bus.in_ready_o}, 0);
      else chk("row_gap_end_ready", bus.in_ready_o, 1);
      gap_n = (gap_n == 3) ? 0 : gap_n + 1;
    end
    if (bus.frame_done_o) done_cnt++;
    if (bus.px_rdy_o) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_px actual=%0h required=none", bus.px_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("px", bus.px_o, e.v);
        chk("start_sobel_in_row", bus.start_sobel_o, 1);
        if (e.gap) gap_n = 1;
        el_cnt++;
      end
    end
  end

  task automatic check_idle_outputs(input string n);
    chk({n, "_px_o"}, bus.px_o, 0);
    chk({n, "_px_rdy"}, bus.px_rdy_o, 0);
    chk({n, "_start_sobel"}, bus.start_sobel_o, 0);
    chk({n, "_frame_done"}, bus.frame_done_o, 0);
    chk({n, "_in_ready"}, bus.in_ready_o, 0);
  endtask

  task automatic run_frame(input bit bp, input bit rnd, input int abort_at);
    int  idx;
    int  cyc;
    bit  v;
    bit  acc;
    done_cnt = 0;
    el_cnt   = 0;
    build_frame(rnd);
    @(posedge clk); #1;
    bus.start_frame_i = 1'b1;
    @(posedge clk);
    idx = 0;
    cyc = 0;
    while (idx < W*H && cyc < 4000) begin
      #1;
      v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.px_valid_i    = v;
      bus.px_i          = img[idx];
      bus.start_frame_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = v && bus.in_ready_o;
      @(posedge clk);
      cyc++;
      if (acc) idx++;
      if (acc && idx == abort_at) begin
        #1;
        bus.px_valid_i    = 1'b0;
        bus.start_frame_i = 1'b0;
        @(negedge clk);
        chk("abort_in_emit", bus.px_rdy_o, 1);
        #2 nreset = 1'b0;
        #1 check_idle_outputs("abort_reset");
        sb.delete();
        gap_n = 0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        return;
      end
    end
    #1;
    bus.px_valid_i    = 1'b0;
    bus.start_frame_i = 1'b0;
    chk("all_pixels_accepted", idx, W*H);
    for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("frame_done_pulses", done_cnt, 1);
    chk("triplet_elements", el_cnt, NTRIP*3);
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    bus.start_frame_i = 1'b0;
    bus.px_valid_i    = 1'b0;
    bus.px_i          = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("idle_no_start");
    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b0, -1);
    run_frame(1'b1, 1'b1, -1);
    run_frame(1'b0, 1'b0, 4*W+4);
    run_frame(1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b1, -1);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/sobel_line_buffer.md
Name: sobel_line_buffer

Overview:
Upstream feeder for the Sobel control stage. Accepts a raster-order grayscale pixel stream, keeps the two previous image lines in register line buffers, and re-emits each column as a serial vertical triplet (top, mid, bottom). It also drives the Sobel stage's start strobe, framing each image row as one sliding-window run. It sits between the grayscale converter output and the Sobel control input.

Parameters:
PIXEL_WIDTH, 8, bits per grayscale pixel; matches the Sobel input pixel width.
IMG_WIDTH, 8, pixels per line; minimum 3.
IMG_HEIGHT, 8, lines per frame; minimum 3.
COL_BITS, $clog2(IMG_WIDTH), width of the column counter.
ROW_BITS, $clog2(IMG_HEIGHT), width of the row counter.

Ports:
clk_i  in  1  single clock; all logic on the rising edge.
nreset_i  in  1  asynchronous active-low reset.
start_frame_i  in  1  frame start request; sampled only in IDLE.
px_valid_i  in  1  input pixel valid.
px_i  in  PIXEL_WIDTH  input grayscale pixel, raster order.
in_ready_o  out  1  the block accepts px_i this cycle.
px_o  out  PIXEL_WIDTH  triplet pixel to the Sobel stage.
px_rdy_o  out  1  px_o is valid (drives the Sobel px_rdy input).
start_sobel_o  out  1  row-active strobe (drives the Sobel start input).
frame_done_o  out  1  one-cycle pulse after the last triplet of the frame.

Behaviour:
- Clock and reset: one clock, clk_i. Reset nreset_i is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; row, col and emit counters 0. Line buffer contents are not reset.
- Reset asserted mid-frame aborts immediately; no partial triplet completes.
- Handshake: a pixel transfers on a rising edge where px_valid_i && in_ready_o.
- in_ready_o is registered and is high only in FILL and WAIT_PX.
- Storage: line0[IMG_WIDTH] holds row r-2; line1[IMG_WIDTH] holds row r-1.
- On each accepted pixel at column c, in one edge: line0[c] <= line1[c]; line1[c] <= px_i; the old line0[c], old line1[c] and px_i are latched into a 3-entry emit register.
- States:
  - IDLE: in_ready_o=0. start_frame_i=1 -> FILL (or WAIT_PX when SOBEL_LB_PAD_EN); row=0, col=0.
  - FILL: rows 0-1 are stored only; nothing is emitted. After accepting col IMG_WIDTH-1 of row 1 -> WAIT_PX with row=2.
  - WAIT_PX: on accept -> EMIT, emit counter 0.
  - EMIT: 3 cycles. px_rdy_o=1 with px_o = top, mid, bottom in that order; in_ready_o=0. After bottom:
    - col < IMG_WIDTH-1: col++, -> WAIT_PX.
    - col = IMG_WIDTH-1 and row < IMG_HEIGHT-1: col=0, row++, -> ROW_GAP.
    - last column of last row: -> DONE.
  - ROW_GAP: exactly 2 cycles with start_sobel_o=0 and in_ready_o=0, then -> WAIT_PX. This gap lets the Sobel stage return to its first-matrix load.
  - DONE: frame_done_o=1 for one cycle -> IDLE.
- Latency: pixel accepted at edge N -> px_rdy_o high on cycles N+1, N+2, N+3. The earliest next accept is edge N+4.
- Throughput: one column per 4 cycles.
- start_sobel_o:
  - Rises at the same edge as the first px_rdy_o of column 0 of every emitting row.
  - Stays high through that row's last triplet.
  - Falls in ROW_GAP and DONE.
  - Never toggles inside a row.
- Frame size: without the pad feature, triplets go out for rows 2..IMG_HEIGHT-1, i.e. (IMG_HEIGHT-2)*IMG_WIDTH triplets per frame.
- px_valid_i while in_ready_o=0: ignored; the source holds the pixel.
- start_frame_i outside IDLE: ignored.
- Counter wrap: col and row never exceed IMG_WIDTH-1 / IMG_HEIGHT-1; the frame ends explicitly in DONE.
- px_o holds its last value when px_rdy_o=0.

Optional Feature:
Macro: SOBEL_LB_PAD_EN.
- With SOBEL_LB_PAD_EN:
  - FILL is skipped; emission starts at row 0.
  - Top is forced to 0 when row<2; mid is forced to 0 when row<1.
  - Output covers IMG_HEIGHT*IMG_WIDTH triplets, with zero-padding at the top border.
- Without SOBEL_LB_PAD_EN: behaviour exactly as in Behaviour; the pad gating logic is absent.

Test Plan:
- Reset: hold nreset_i=0 -> all outputs 0, in_ready_o=0. Release, no start -> stays in IDLE with in_ready_o=0.
- 8x8 frame, px = row*8+col, px_valid_i always 1:
  - The first triplet is 0,8,16 on px_rdy_o.
  - start_sobel_o rises with the value 0.
  - The last triplet is 47,55,63.
  - 48 triplets total; frame_done_o pulses once.
- Row boundary: after triplet 7,15,23 -> start_sobel_o=0 and in_ready_o=0 for exactly 2 cycles. The next triplet is 8,16,24 with start_sobel_o high again.
- Backpressure: px_valid_i toggled 1/0 randomly -> triplet sequence is identical to the continuous case; no accept ever happens while in_ready_o=0.
- Mid-frame reset during EMIT (row 4, col 3), then a new start -> outputs clear asynchronously; the new frame's first triplet is 0,8,16.
- SOBEL_LB_PAD_EN, same 8x8 frame -> first triplet is 0,0,0 (col 0); second is 0,0,1; row 1 col 0 is 0,0,8; 64 triplets total.
